// File: rtl/host_cmd_decoder_if.sv
// Host-to-FPGA 32-bit write stream.
// The host side drives open/enable/data; the decoder returns full.
interface host_cmd_decoder_if;
    logic        WR_OPEN;
    logic        WR_EN;
    logic [31:0] WR_DATA;
    logic        WR_FULL;

    modport master (
        output WR_OPEN,
        output WR_EN,
        output WR_DATA,
        input  WR_FULL
    );

    modport slave (
        input  WR_OPEN,
        input  WR_EN,
        input  WR_DATA,
        output WR_FULL
    );
endinterface

// File: rtl/host_cmd_decoder.sv
// Host command frame decoder: word FIFO, framing/checksum FSM,
// and the ADC readout configuration and run-control registers.
module host_cmd_decoder #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 8
) (
    input  logic               CLK,
    input  logic               RST,
    host_cmd_decoder_if.slave  wr,
    output logic [6:0]         CH_EN,
    output logic [15:0]        ADC_CFG,
    output logic [9:0]         VETO_LIMIT,
    output logic               RUN,
    output logic               START_PULSE,
    output logic               CMD_OK,
    output logic               CMD_ERR,
    output logic [7:0]         ERR_CNT,
    output logic [7:0]         LAST_SEQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);
    localparam logic [7:0] MAX_L    = 8'(MAX_LEN);
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] OP_WR    = 8'h01;
    localparam logic [7:0] OP_START = 8'h02;
    localparam logic [7:0] OP_STOP  = 8'h03;

    typedef struct packed {
        logic [7:0] sync;
        logic [7:0] op;
        logic [7:0] len;
        logic [7:0] seq;
    } hdr_t;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        TRAILER,
        EXEC
    } state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          pop_req;
    logic          avail;
    logic [31:0]   word;
    hdr_t          hdr_w;

    state_t        state;
    state_t        state_d;
    logic [7:0]    op_q;
    logic [7:0]    len_q;
    logic [7:0]    seq_q;
    logic [7:0]    rem;
    logic [31:0]   csum;
    logic          match;
    logic          legal;
    logic [2:0]    vld;
    logic [6:0]    stg_ch;
    logic [15:0]   stg_cfg;
    logic [9:0]    stg_veto;

    logic hdr_take;
    logic pay_take;
    logic trl_take;
    logic hunt_err;
    logic exec_ok;
    logic exec_err;

    assign wr.WR_FULL = (count == FULL_N);
    assign push  = wr.WR_EN && wr.WR_OPEN && !wr.WR_FULL;
    assign avail = (count != '0);
    assign pop   = pop_req && avail;
    assign word  = mem[rd_ptr];
    assign hdr_w = word;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr.WR_DATA;
        end
    end

    // Closing the stream empties the queue in one cycle.
    always_ff @(posedge CLK) begin
        if (RST || !wr.WR_OPEN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            (op_q == OP_WR):    legal = 1'b1;
            (op_q == OP_START): legal = (len_q == 8'd0);
            (op_q == OP_STOP):  legal = (len_q == 8'd0);
            default:            legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HUNT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        pop_req  = 1'b0;
        hdr_take = 1'b0;
        pay_take = 1'b0;
        trl_take = 1'b0;
        hunt_err = 1'b0;
        exec_ok  = 1'b0;
        exec_err = 1'b0;
        if (!wr.WR_OPEN) begin
            state_d = HUNT;
        end else begin
            unique case (state)
                HUNT: begin
                    pop_req = 1'b1;
                    if (avail && hdr_w.sync == SYNC) begin
                        hdr_take = 1'b1;
                        if (hdr_w.len > MAX_L) begin
                            hunt_err = 1'b1;
                        end else if (hdr_w.len == 8'd0) begin
                            state_d = TRAILER;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    pop_req = 1'b1;
                    if (avail) begin
                        pay_take = 1'b1;
                        if (rem == 8'd1) state_d = TRAILER;
                    end
                end
                TRAILER: begin
                    pop_req = 1'b1;
                    if (avail) begin
                        trl_take = 1'b1;
                        state_d  = EXEC;
                    end
                end
                EXEC: begin
                    exec_ok  = match && legal;
                    exec_err = !(match && legal);
                    state_d  = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q        <= '0;
            len_q       <= '0;
            seq_q       <= '0;
            rem         <= '0;
            csum        <= '0;
            match       <= 1'b0;
            vld         <= '0;
            stg_ch      <= '0;
            stg_cfg     <= '0;
            stg_veto    <= '0;
            CH_EN       <= '0;
            ADC_CFG     <= '0;
            VETO_LIMIT  <= 10'd450;
            RUN         <= 1'b0;
            START_PULSE <= 1'b0;
            CMD_OK      <= 1'b0;
            CMD_ERR     <= 1'b0;
            ERR_CNT     <= '0;
            LAST_SEQ    <= '0;
        end else begin
            START_PULSE <= 1'b0;
            CMD_OK      <= 1'b0;
            CMD_ERR     <= 1'b0;
            if (!wr.WR_OPEN) begin
                vld <= '0;
            end
            if (hdr_take) begin
                op_q  <= hdr_w.op;
                len_q <= hdr_w.len;
                seq_q <= hdr_w.seq;
                rem   <= hdr_w.len;
                csum  <= word;
                vld   <= '0;
            end
            if (pay_take) begin
                csum <= csum ^ word;
                rem  <= rem - 8'd1;
                unique case (word[31:24])
                    8'd0: begin
                        stg_ch <= word[6:0];
                        vld[0] <= 1'b1;
                    end
                    8'd1: begin
                        stg_cfg <= word[15:0];
                        vld[1]  <= 1'b1;
                    end
                    8'd2: begin
                        stg_veto <= word[9:0];
                        vld[2]   <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (trl_take) begin
                match <= (word == csum);
            end
            if (exec_ok) begin
                CMD_OK   <= 1'b1;
                LAST_SEQ <= seq_q;
                if (op_q == OP_WR) begin
                    if (vld[0]) CH_EN      <= stg_ch;
                    if (vld[1]) ADC_CFG    <= stg_cfg;
                    if (vld[2]) VETO_LIMIT <= stg_veto;
                end
                if (op_q == OP_START) begin
                    RUN         <= 1'b1;
                    START_PULSE <= 1'b1;
                end
                if (op_q == OP_STOP) begin
                    RUN <= 1'b0;
                end
            end
            if (exec_err || hunt_err) begin
                CMD_ERR <= 1'b1;
                if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_host_cmd_decoder.sv
// Directed bench for host_cmd_decoder: framing, checksum,
// run control, backpressure, abort and reset.
module tb_host_cmd_decoder;
    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  CH_EN;
    logic [15:0] ADC_CFG;
    logic [9:0]  VETO_LIMIT;
    logic        RUN;
    logic        START_PULSE;
    logic        CMD_OK;
    logic        CMD_ERR;
    logic [7:0]  ERR_CNT;
    logic [7:0]  LAST_SEQ;

    always #5 CLK = ~CLK;

    host_cmd_decoder_if wr();

    host_cmd_decoder #(
        .FIFO_DEPTH(16),
        .MAX_LEN(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .wr(wr),
        .CH_EN(CH_EN),
        .ADC_CFG(ADC_CFG),
        .VETO_LIMIT(VETO_LIMIT),
        .RUN(RUN),
        .START_PULSE(START_PULSE),
        .CMD_OK(CMD_OK),
        .CMD_ERR(CMD_ERR),
        .ERR_CNT(ERR_CNT),
        .LAST_SEQ(LAST_SEQ)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] w);
        @(negedge CLK);
        wr.WR_EN   = 1'b1;
        wr.WR_DATA = w;
    endtask

    task automatic idle();
        @(negedge CLK);
        wr.WR_EN   = 1'b0;
        wr.WR_DATA = '0;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    // In-order result monitor for the backpressure burst.
    logic mon_en = 1'b0;
    int   k = 0;
    int   mon_err = 0;
    always @(negedge CLK) begin
        if (mon_en) begin
            if (CMD_OK) begin
                check("pump_seq", LAST_SEQ, 32'(8'h40 + k));
                check("pump_start", START_PULSE, (k % 2 == 0));
                k = k + 1;
            end
            if (CMD_ERR) mon_err = mon_err + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] q[$];
    logic [31:0] h;
    int idx;
    int cyc;
    int drops;
    logic saw_full;

    initial begin
        RST        = 1'b1;
        wr.WR_OPEN = 1'b1;
        wr.WR_EN   = 1'b0;
        wr.WR_DATA = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_ch_en", CH_EN, 0);
        check("rst_adc_cfg", ADC_CFG, 0);
        check("rst_veto", VETO_LIMIT, 450);
        check("rst_run", RUN, 0);
        check("rst_ok", CMD_OK, 0);
        check("rst_err", CMD_ERR, 0);
        check("rst_err_cnt", ERR_CNT, 0);
        check("rst_seq", LAST_SEQ, 0);
        check("rst_full", wr.WR_FULL, 0);

        // register write
        put(32'hA501_0207);
        put(32'h0000_0055);
        put(32'h0200_01F4);
        put(32'hA701_03A6);
        idle();
        check("wr_ok_t1", CMD_OK, 0);
        idle();
        check("wr_ok_t2", CMD_OK, 0);
        idle();
        check("wr_ok_t3", CMD_OK, 1);
        check("wr_err", CMD_ERR, 0);
        check("wr_ch_en", CH_EN, 7'h55);
        check("wr_veto", VETO_LIMIT, 500);
        check("wr_adc_cfg", ADC_CFG, 0);
        check("wr_seq", LAST_SEQ, 8'h07);
        idle();
        check("wr_ok_t4", CMD_OK, 0);

        // start then stop
        put(32'hA502_0010);
        put(32'hA502_0010);
        idles(3);
        check("start_ok", CMD_OK, 1);
        check("start_pulse", START_PULSE, 1);
        check("start_run", RUN, 1);
        check("start_seq", LAST_SEQ, 8'h10);
        idle();
        check("start_pulse_end", START_PULSE, 0);
        put(32'hA503_0011);
        put(32'hA503_0011);
        idles(3);
        check("stop_ok", CMD_OK, 1);
        check("stop_pulse", START_PULSE, 0);
        check("stop_run", RUN, 0);
        check("stop_seq", LAST_SEQ, 8'h11);
        idle();

        // junk word then START
        put(32'h1234_5678);
        put(32'hA502_0020);
        put(32'hA502_0020);
        idles(3);
        check("junk_ok", CMD_OK, 1);
        check("junk_run", RUN, 1);
        check("junk_seq", LAST_SEQ, 8'h20);
        check("junk_err_cnt", ERR_CNT, 0);
        idle();

        // header with len above the maximum
        put(32'hA501_0930);
        idle();
        idle();
        check("len9_err", CMD_ERR, 1);
        check("len9_ok", CMD_OK, 0);
        check("len9_err_cnt", ERR_CNT, 1);
        idle();
        check("len9_err_end", CMD_ERR, 0);

        // bad checksum
        put(32'hA501_0112);
        put(32'h0100_1234);
        put(32'hA401_1327);
        idles(3);
        check("csum_err", CMD_ERR, 1);
        check("csum_ok", CMD_OK, 0);
        check("csum_err_cnt", ERR_CNT, 2);
        check("csum_adc_cfg", ADC_CFG, 0);
        check("csum_ch_en", CH_EN, 7'h55);
        check("csum_seq", LAST_SEQ, 8'h20);
        idle();

        // backpressure burst: 40 alternating START/STOP frames
        for (int i = 0; i < 40; i++) begin
            h = {8'hA5, (i % 2 == 0) ? 8'h02 : 8'h03, 8'h00, 8'(8'h40 + i)};
            q.push_back(h);
            q.push_back(h);
        end
        idx = 0;
        cyc = 0;
        drops = 0;
        saw_full = 1'b0;
        mon_en = 1'b1;
        while (idx < q.size() && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            wr.WR_EN   = 1'b1;
            wr.WR_DATA = q[idx];
            if (wr.WR_FULL) begin
                saw_full = 1'b1;
                drops++;
            end else begin
                idx++;
            end
        end
        idle();
        cyc = 0;
        while (k < 40 && cyc < 400) begin
            idle();
            cyc++;
        end
        idles(4);
        mon_en = 1'b0;
        check("pump_sent", idx, 80);
        check("pump_done", k, 40);
        check("pump_full_seen", saw_full, 1);
        check("pump_dropped", (drops > 0), 1);
        check("pump_no_err", mon_err, 0);
        check("pump_err_cnt", ERR_CNT, 2);
        check("pump_run", RUN, 0);
        check("pump_seq_last", LAST_SEQ, 8'h67);
        check("pump_full_clr", wr.WR_FULL, 0);

        // abort mid-payload, then a fresh frame
        put(32'hA501_0550);
        put(32'h0000_0011);
        put(32'h0000_0022);
        @(negedge CLK);
        wr.WR_EN   = 1'b0;
        wr.WR_OPEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("abort_no_ok", CMD_OK, 0);
            check("abort_no_err", CMD_ERR, 0);
        end
        wr.WR_OPEN = 1'b1;
        check("abort_empty", wr.WR_FULL, 0);
        put(32'hA501_0351);
        put(32'h0100_BEEF);
        put(32'h0500_1111);
        put(32'h0100_CAFE);
        put(32'hA001_6651);
        idle();
        idle();
        check("reopen_ok_t2", CMD_OK, 0);
        idle();
        check("reopen_ok", CMD_OK, 1);
        check("reopen_err", CMD_ERR, 0);
        check("reopen_adc_cfg", ADC_CFG, 16'hCAFE);
        check("reopen_ch_en", CH_EN, 7'h55);
        check("reopen_seq", LAST_SEQ, 8'h51);
        check("reopen_err_cnt", ERR_CNT, 2);
        idle();

        // reset in the middle of a frame
        put(32'hA501_0170);
        put(32'h0000_0011);
        @(negedge CLK);
        wr.WR_EN = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mrst_ch_en", CH_EN, 0);
        check("mrst_adc_cfg", ADC_CFG, 0);
        check("mrst_veto", VETO_LIMIT, 450);
        check("mrst_err_cnt", ERR_CNT, 0);
        check("mrst_seq", LAST_SEQ, 0);
        check("mrst_full", wr.WR_FULL, 0);
        put(32'hA502_0077);
        put(32'hA502_0077);
        idles(3);
        check("mrst_start_ok", CMD_OK, 1);
        check("mrst_start_run", RUN, 1);
        check("mrst_start_seq", LAST_SEQ, 8'h77);
        check("mrst_start_err_cnt", ERR_CNT, 0);
        idles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
